// File: rtl/axi_irq_ctrl_pkg.sv
// axi_irq_ctrl_pkg: register offsets, response codes and FSM state types for axi_irq_ctrl
package axi_irq_ctrl_pkg;
  localparam logic [31:0] OFF_ISR = 32'h00;
  localparam logic [31:0] OFF_IER = 32'h04;
  localparam logic [31:0] OFF_IAR = 32'h08;
  localparam logic [31:0] OFF_MER = 32'h0C;
  localparam logic [31:0] OFF_IPR = 32'h10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  function automatic logic addr_err(input logic [31:0] off);
    return (off[1:0] != 2'b00) || (off > OFF_IPR);
  endfunction
endpackage

// File: rtl/axi_irq_ctrl_if.sv
// axi_irq_ctrl_if: AXI4-Lite bus bundle; master drives addresses/data/valids, slave drives readies/responses
interface axi_irq_ctrl_if #(parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_irq_ctrl_axil_slave_if.sv
// axil_slave_if: AXI4-Lite write/read handshake FSMs presenting a simple register access port
//   s_axi_aclk/s_axi_aresetn : clock, async active-low reset
//   s_axi                    : AXI4-Lite slave modport
//   o_wr_*                   : one-cycle write strobe with address/data/byte strobes; i_wr_err selects SLVERR
//   o_rd_*/i_rd_data         : one-cycle read strobe with address; data/i_rd_err latched into R channel
module axil_slave_if import axi_irq_ctrl_pkg::*; #(
  parameter int ADDR_W = 5
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  axi_irq_ctrl_if.slave     s_axi,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic [3:0]        o_wr_strb,
  input  logic              i_wr_err,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  input  logic              i_rd_err
);
  wr_state_t r_wst, w_wst_nxt;
  rd_state_t r_rst, w_rst_nxt;
  logic [1:0] r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic w_unused;
  assign w_unused = ^{s_axi.awprot, s_axi.arprot};
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wst <= W_IDLE;
      r_rst <= R_IDLE;
    end else begin
      r_wst <= w_wst_nxt;
      r_rst <= w_rst_nxt;
    end
  end
  // AW and W are accepted together only; a lone channel simply waits
  always_comb begin
    o_wr_en = (r_wst == W_IDLE) && s_axi.awvalid && s_axi.wvalid;
    o_rd_en = (r_rst == R_IDLE) && s_axi.arvalid;
    w_wst_nxt = o_wr_en ? W_RESP : (r_wst == W_RESP && s_axi.bready) ? W_IDLE : r_wst;
    w_rst_nxt = o_rd_en ? R_DATA : (r_rst == R_DATA && s_axi.rready) ? R_IDLE : r_rst;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
      r_rdata <= '0;
    end else begin
      if (o_wr_en) r_bresp <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
      if (o_rd_en) begin
        r_rresp <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
        r_rdata <= i_rd_err ? '0 : i_rd_data;
      end
    end
  end
  assign o_wr_addr = s_axi.awaddr;
  assign o_wr_data = s_axi.wdata;
  assign o_wr_strb = s_axi.wstrb;
  assign o_rd_addr = s_axi.araddr;
  assign s_axi.awready = o_wr_en;
  assign s_axi.wready = o_wr_en;
  assign s_axi.bvalid = (r_wst == W_RESP);
  assign s_axi.bresp = r_bresp;
  assign s_axi.arready = o_rd_en;
  assign s_axi.rvalid = (r_rst == R_DATA);
  assign s_axi.rresp = r_rresp;
  assign s_axi.rdata = r_rdata;
endmodule

// File: rtl/axi_irq_ctrl.sv
// axi_irq_ctrl: AXI4-Lite interrupt controller latching source edges into ISR and driving one CPU irq
//   s_axi_aclk/s_axi_aresetn : clock, async active-low reset
//   irq_in[N_IRQ]            : active-high sources, synchronous to s_axi_aclk
//   irq                      : registered CPU interrupt
//   s_axi                    : AXI4-Lite slave (ISR 0x00, IER 0x04, IAR 0x08, MER 0x0C, IPR 0x10)
module axi_irq_ctrl import axi_irq_ctrl_pkg::*; #(
  parameter int N_IRQ = 4,
  parameter int ADDR_W = 5
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq,
  axi_irq_ctrl_if.slave    s_axi
);
  logic w_wr_en, w_rd_en, w_wr_err, w_rd_err, w_wr_ok;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [3:0] w_wr_strb;
  logic [31:0] w_wr_data, w_rd_data, w_wr_off, w_rd_off, w_wmask, w_wval;
  logic [N_IRQ-1:0] r_irq_q, r_isr, r_ier, w_edge, w_clr;
  logic r_mer, r_irq;
  axil_slave_if #(.ADDR_W(ADDR_W)) u_slv (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .s_axi         (s_axi),
    .o_wr_en       (w_wr_en),
    .o_wr_addr     (w_wr_addr),
    .o_wr_data     (w_wr_data),
    .o_wr_strb     (w_wr_strb),
    .i_wr_err      (w_wr_err),
    .o_rd_en       (w_rd_en),
    .o_rd_addr     (w_rd_addr),
    .i_rd_data     (w_rd_data),
    .i_rd_err      (w_rd_err)
  );
  always_comb begin
    w_wr_off = 32'(w_wr_addr);
    w_rd_off = 32'(w_rd_addr);
    w_wr_err = addr_err(w_wr_off);
    w_rd_err = addr_err(w_rd_off);
    w_wr_ok = w_wr_en && !w_wr_err;
    w_wmask = {{8{w_wr_strb[3]}}, {8{w_wr_strb[2]}}, {8{w_wr_strb[1]}}, {8{w_wr_strb[0]}}};
    w_wval = w_wr_data & w_wmask;
    w_edge = irq_in & ~r_irq_q;
    w_clr = (w_wr_ok && w_wr_off == OFF_IAR) ? N_IRQ'(w_wval) : '0;
    // read mux sees pre-update register state; w_rd_en is only used as a qualifier by the slave
    w_rd_data = (w_rd_off == OFF_ISR) ? 32'(r_isr) :
                (w_rd_off == OFF_IER) ? 32'(r_ier) :
                (w_rd_off == OFF_MER) ? {31'b0, r_mer} :
                (w_rd_off == OFF_IPR) ? 32'(r_isr & r_ier) : 32'b0;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_irq_q <= '0;
      r_isr <= '0;
      r_ier <= '0;
      r_mer <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_irq_q <= irq_in;
      // a fresh edge on the same bit overrides a concurrent acknowledge
      r_isr <= (r_isr & ~w_clr) | w_edge;
      if (w_wr_ok && w_wr_off == OFF_IER) r_ier <= N_IRQ'((32'(r_ier) & ~w_wmask) | w_wval);
      if (w_wr_ok && w_wr_off == OFF_MER && w_wr_strb[0]) r_mer <= w_wr_data[0];
      r_irq <= r_mer & |(r_isr & r_ier);
    end
  end
  assign irq = r_irq;
endmodule
